// File: rtl/vga_timing_gen.sv
// Raster timing generator: porch/sync parametrised counters with
// zero-skew registered sync/blank/de, sof/eol strobes and frame count.
module vga_timing_gen #(
  parameter int H_ADDR    = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ADDR    = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 8
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               restart,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ADDR + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ADDR + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Compare constants carry one extra bit so a sync ending exactly
  // at 2^CNT_W does not truncate to zero.
  localparam logic [CNT_W:0] H_VIS = (CNT_W+1)'(H_ADDR);
  localparam logic [CNT_W:0] H_SB  = (CNT_W+1)'(H_ADDR + H_FP);
  localparam logic [CNT_W:0] H_SE  = (CNT_W+1)'(H_ADDR + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_VIS = (CNT_W+1)'(V_ADDR);
  localparam logic [CNT_W:0] V_SB  = (CNT_W+1)'(V_ADDR + V_FP);
  localparam logic [CNT_W:0] V_SE  = (CNT_W+1)'(V_ADDR + V_FP + V_SYNC);

  if (H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W) ||
      H_TOTAL < 2 || V_TOTAL < 1 ||
      H_ADDR < 1 || V_ADDR < 1 || FRAME_W < 1 ||
      H_FP < 0 || H_SYNC < 0 || H_BP < 0 ||
      V_FP < 0 || V_SYNC < 0 || V_BP < 0) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               sof_q, sof_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;
  logic               de_q, de_d;
  logic               last_q, last_d;

  logic               h_wrap;
  logic               v_wrap;
  logic [CNT_W:0]     hx;
  logic [CNT_W:0]     vx;
  logic               hs_act;
  logic               vs_act;

  assign h_wrap = (hcount_q == H_LAST);
  assign v_wrap = (vcount_q == V_LAST);

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    sof_d    = 1'b0;
    unique case (1'b1)
      restart: begin
        hcount_d = '0;
        vcount_d = '0;
        sof_d    = 1'b1;
      end
      (!restart && ce && h_wrap): begin
        hcount_d = '0;
        if (v_wrap) begin
          vcount_d = '0;
          frame_d  = frame_q + FRAME_W'(1);
          sof_d    = 1'b1;
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end
      (!restart && ce && !h_wrap): begin
        hcount_d = hcount_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Levels decode the next counter value so they line up with it.
  always_comb begin
    hx      = {1'b0, hcount_d};
    vx      = {1'b0, vcount_d};
    hs_act  = (hx >= H_SB) && (hx < H_SE);
    vs_act  = (vx >= V_SB) && (vx < V_SE);
    hblnk_d = (hx >= H_VIS);
    vblnk_d = (vx >= V_VIS);
    de_d    = ~hblnk_d & ~vblnk_d;
    hsync_d = hs_act ^ ~HSYNC_POL;
    vsync_d = vs_act ^ ~VSYNC_POL;
    last_d  = (hcount_d == H_LAST);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      frame_q  <= '0;
      sof_q    <= 1'b0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b1;
      last_q   <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      frame_q  <= frame_d;
      sof_q    <= sof_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      de_q     <= de_d;
      last_q   <= last_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign frame_cnt = frame_q;
  assign sof       = sof_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign hblnk     = hblnk_q;
  assign vblnk     = vblnk_q;
  assign de        = de_q;
  // Column flag is registered; ce gating keeps eol low on stalled pixels.
  assign eol       = last_q & ce;

endmodule
